// File: rtl/ahb_sram_arbiter_if.sv
// rtl/ahb_sram_arbiter_if.sv - AHB-Lite pins between the arbiter (master) and the SRAM converter (slave)
interface ahb_sram_arbiter_if #(
  parameter int DW = 32
);
  logic          HSEL;
  logic [31:0]   HADDR;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic [1:0]    HRESP;
  logic [DW-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_arbiter.sv
// rtl/ahb_sram_arbiter.sv - two-client round-robin AHB-Lite master for a word SRAM
// AP/DP registers advance together on HREADY; a retiring DP becomes a one-cycle response pulse.
module ahb_sram_arbiter #(
  parameter int DW = 32
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_write,
  input  logic [31:0]        req0_addr,
  input  logic [DW-1:0]      req0_wdata,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_write,
  input  logic [31:0]        req1_addr,
  input  logic [DW-1:0]      req1_wdata,
  output logic               rsp0_valid,
  output logic [DW-1:0]      rsp0_rdata,
  output logic               rsp0_err,
  output logic               rsp1_valid,
  output logic [DW-1:0]      rsp1_rdata,
  output logic               rsp1_err,
  ahb_sram_arbiter_if.master ahb
);
  logic          last;
  logic          gnt_id;
  logic          accept;
  logic          ap_valid;
  logic          ap_owner;
  logic          ap_write;
  logic [31:0]   ap_addr;
  logic [DW-1:0] ap_wdata;
  logic          dp_valid;
  logic          dp_owner;
  logic          dp_write;
  logic [DW-1:0] dp_wdata;
  logic [DW-1:0] retire_rdata;
  logic          retire_err;

  // With no contest the grant defaults to client 0, so req0_ready mirrors HREADY when idle.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = ~last;
    else if (req1_valid)          gnt_id = 1'b1;
  end

  assign accept     = ahb.HREADY && (req0_valid || req1_valid);
  assign req0_ready = ahb.HREADY && !gnt_id;
  assign req1_ready = ahb.HREADY && gnt_id;

  assign retire_rdata = dp_write ? '0 : ahb.HRDATA;
  assign retire_err   = |ahb.HRESP;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last       <= 1'b1;
      ap_valid   <= 1'b0;
      ap_owner   <= 1'b0;
      ap_write   <= 1'b0;
      ap_addr    <= '0;
      ap_wdata   <= '0;
      dp_valid   <= 1'b0;
      dp_owner   <= 1'b0;
      dp_write   <= 1'b0;
      dp_wdata   <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (ahb.HREADY) begin
        if (dp_valid && !dp_owner) begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= retire_rdata;
          rsp0_err   <= retire_err;
        end
        if (dp_valid && dp_owner) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= retire_rdata;
          rsp1_err   <= retire_err;
        end
        dp_valid <= ap_valid;
        dp_owner <= ap_owner;
        dp_write <= ap_write;
        dp_wdata <= ap_wdata;
        ap_valid <= accept;
        if (accept) begin
          last     <= gnt_id;
          ap_owner <= gnt_id;
          ap_write <= gnt_id ? req1_write : req0_write;
          ap_addr  <= gnt_id ? req1_addr  : req0_addr;
          ap_wdata <= gnt_id ? req1_wdata : req0_wdata;
        end
      end
    end
  end

  assign ahb.HSEL   = ap_valid;
  assign ahb.HADDR  = ap_addr;
  assign ahb.HWRITE = ap_valid && ap_write;
  assign ahb.HTRANS = ap_valid ? 2'b10 : 2'b00;
  assign ahb.HSIZE  = 3'b010;
  assign ahb.HBURST = 3'b000;
  assign ahb.HWDATA = dp_wdata;
endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// tb/tb_ahb_sram_arbiter.sv - scoreboard bench for ahb_sram_arbiter with an AHB word-SRAM slave model
module tb_ahb_sram_arbiter;
  localparam int          DW       = 32;
  localparam logic [31:0] ERR_ADDR = 32'h3F0;

  typedef struct { logic write; logic [31:0] addr; logic [31:0] data; } cmd_t;
  typedef struct { int owner; logic [31:0] rdata; logic err; int acc_edge; } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0, req0_wdata = '0, req1_wdata = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;

  ahb_sram_arbiter_if #(.DW(DW)) ahb ();

  ahb_sram_arbiter #(.DW(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ahb(ahb)
  );

  initial forever #5 HCLK = ~HCLK;

  // Slave: stalls one cycle when a read in AP hits the word a DP write is storing.
  logic [31:0] mem [0:255];
  logic        s_dp_valid, s_dp_write, s_stalled, s_wait;
  logic [31:0] s_dp_addr;
  bit          wait_en = 0;
  logic        raw_hit;

  assign raw_hit = ahb.HSEL && !ahb.HWRITE && s_dp_valid && s_dp_write &&
                   (ahb.HADDR[31:2] == s_dp_addr[31:2]) && !s_stalled;
  assign ahb.HREADY = !(raw_hit || s_wait);
  assign ahb.HRDATA = (s_dp_valid && !s_dp_write) ? mem[s_dp_addr[9:2]] : 32'hBAD0BAD0;
  assign ahb.HRESP  = (s_dp_valid && s_dp_addr == ERR_ADDR) ? 2'b01 : 2'b00;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_addr  <= '0;
      s_stalled  <= 1'b0;
      s_wait     <= 1'b0;
    end else begin
      s_wait <= wait_en && !s_wait && ($urandom_range(0, 3) == 0);
      if (ahb.HREADY) begin
        if (s_dp_valid && s_dp_write) mem[s_dp_addr[9:2]] <= ahb.HWDATA;
        s_dp_valid <= ahb.HSEL;
        s_dp_write <= ahb.HWRITE;
        s_dp_addr  <= ahb.HADDR;
        s_stalled  <= 1'b0;
      end else if (raw_hit) begin
        mem[s_dp_addr[9:2]] <= ahb.HWDATA;
        s_stalled <= 1'b1;
      end
    end
  end

  cmd_t        cmdq0[$], cmdq1[$];
  exp_t        expq[$];
  logic [31:0] ref_mem [int];
  int          acc_owner_log[$], acc_edge_log[$], lat_log[$], err_log[$];
  int          errors = 0, checks = 0, cyc = 0, gap_pct = 0, rsp_count = 0;
  int          stall_cnt = 0, stall_ready_cnt = 0;
  bit          acc0 = 0, acc1 = 0;
  logic [31:0] last_rdata0 = '0, last_rdata1 = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic record_accept(int owner, cmd_t c);
    exp_t e;
    e.owner    = owner;
    e.err      = (c.addr == ERR_ADDR);
    e.acc_edge = cyc + 1;
    if (c.write) begin
      ref_mem[c.addr[31:2]] = c.data;
      e.rdata = '0;
    end else begin
      e.rdata = ref_mem.exists(c.addr[31:2]) ? ref_mem[c.addr[31:2]] : 32'h0;
    end
    expq.push_back(e);
    acc_owner_log.push_back(owner);
    acc_edge_log.push_back(cyc + 1);
  endtask

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // Monitor: predicts accepts for the coming edge and scores retired responses.
  initial forever begin
    @(negedge HCLK);
    acc0 = HRESETn && req0_valid && req0_ready;
    acc1 = HRESETn && req1_valid && req1_ready;
    if (acc0 && acc1) check("dual_grant", {acc0, acc1}, 2'b00);
    if (acc0) record_accept(0, cmdq0[0]);
    if (acc1) record_accept(1, cmdq1[0]);
    if (HRESETn && !ahb.HREADY) begin
      stall_cnt++;
      if (req0_ready || req1_ready) stall_ready_cnt++;
    end
    if (rsp0_valid && rsp1_valid) check("dual_rsp", {rsp0_valid, rsp1_valid}, 2'b01);
    if (rsp0_valid || rsp1_valid) begin
      rsp_count++;
      if (rsp0_valid) last_rdata0 = rsp0_rdata;
      if (rsp1_valid) last_rdata1 = rsp1_rdata;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp0=%0b rsp1=%0b required none", rsp0_valid, rsp1_valid);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("rsp_owner", rsp1_valid ? 1 : 0, e.owner);
        check("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.rdata);
        check("rsp_err", rsp1_valid ? rsp1_err : rsp0_err, e.err);
        lat_log.push_back(cyc - e.acc_edge);
        err_log.push_back(rsp1_valid ? int'(rsp1_err) : int'(rsp0_err));
      end
    end
  end

  // Driver: holds a presented request until accepted, optionally inserting idle gaps.
  initial forever begin
    @(posedge HCLK);
    #1;
    if (acc0 && cmdq0.size() > 0) void'(cmdq0.pop_front());
    if (acc1 && cmdq1.size() > 0) void'(cmdq1.pop_front());
    if (acc0 || !req0_valid)
      req0_valid = (cmdq0.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
    if (acc1 || !req1_valid)
      req1_valid = (cmdq1.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
    if (req0_valid) begin
      req0_write = cmdq0[0].write; req0_addr = cmdq0[0].addr; req0_wdata = cmdq0[0].data;
    end
    if (req1_valid) begin
      req1_write = cmdq1[0].write; req1_addr = cmdq1[0].addr; req1_wdata = cmdq1[0].data;
    end
  end

  function automatic cmd_t mk(logic w, logic [31:0] a, logic [31:0] d);
    cmd_t c;
    c.write = w; c.addr = a; c.data = d;
    return c;
  endfunction

  task automatic drain(string name, int budget);
    int n = 0;
    while ((cmdq0.size() > 0 || cmdq1.size() > 0 || expq.size() > 0 || req0_valid || req1_valid)
           && n < budget) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d responses pending required 0", name, expq.size());
      cmdq0.delete(); cmdq1.delete(); expq.delete();
    end
    repeat (2) @(negedge HCLK);
  endtask

  initial begin
    int base, n_rsp;
    repeat (3) @(negedge HCLK);
    check("rst_hsel", ahb.HSEL, 0);
    check("rst_htrans", ahb.HTRANS, 2'b00);
    check("rst_haddr", ahb.HADDR, 0);
    check("rst_hwrite", ahb.HWRITE, 0);
    check("rst_hwdata", ahb.HWDATA, 0);
    check("rst_hsize", ahb.HSIZE, 3'b010);
    check("rst_hburst", ahb.HBURST, 3'b000);
    check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
    check("rst_rdata", {rsp0_rdata, rsp1_rdata}, 0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("idle_ready0", req0_ready, 1);

    // Single write then read on client 0.
    cmdq0.push_back(mk(1, 32'h100, 32'hDEADBEEF));
    drain("wr100", 50);
    cmdq0.push_back(mk(0, 32'h100, 0));
    drain("rd100", 50);
    check("rd100_data", last_rdata0, 32'hDEADBEEF);
    check("rd100_latency", lat_log[lat_log.size()-1], 2);

    // Round-robin alternation with both clients holding valid.
    cmdq1.push_back(mk(1, 32'h0, 32'hA0A0A0A0));
    cmdq1.push_back(mk(1, 32'h4, 32'hB4B4B4B4));
    drain("rr_fill", 50);
    base = acc_owner_log.size();
    cmdq0.push_back(mk(0, 32'h0, 0)); cmdq0.push_back(mk(0, 32'h4, 0));
    cmdq1.push_back(mk(0, 32'h4, 0)); cmdq1.push_back(mk(0, 32'h0, 0));
    drain("rr", 50);
    for (int i = 0; i < 4; i++) check("rr_grant", acc_owner_log[base+i], i % 2);
    check("rr_b2b", acc_edge_log[base+3] - acc_edge_log[base], 3);

    // Read-after-write conflict across clients.
    stall_cnt = 0;
    stall_ready_cnt = 0;
    cmdq0.push_back(mk(1, 32'h40, 32'h12345678));
    @(negedge HCLK);
    cmdq1.push_back(mk(0, 32'h40, 0));
    drain("raw", 50);
    check("raw_stalls", stall_cnt, 1);
    check("raw_ready_in_stall", stall_ready_cnt, 0);
    check("raw_rdata", last_rdata1, 32'h12345678);
    check("raw_wr_latency", lat_log[lat_log.size()-2], 3);
    check("raw_rd_latency", lat_log[lat_log.size()-1], 3);

    // Streaming writes then reads from client 0.
    base = acc_edge_log.size();
    for (int i = 0; i < 8; i++) cmdq0.push_back(mk(1, 32'(i * 4), 32'(i + 1)));
    drain("stream_wr", 80);
    check("stream_wr_b2b", acc_edge_log[base+7] - acc_edge_log[base], 7);
    base = acc_edge_log.size();
    for (int i = 0; i < 8; i++) cmdq0.push_back(mk(0, 32'(i * 4), 0));
    drain("stream_rd", 80);
    check("stream_rd_b2b", acc_edge_log[base+7] - acc_edge_log[base], 7);
    check("stream_last_data", last_rdata0, 32'd8);

    // Error response on one data phase only.
    base = err_log.size();
    cmdq0.push_back(mk(1, ERR_ADDR, 32'h55));
    cmdq0.push_back(mk(0, 32'h100, 0));
    drain("hresp", 50);
    check("hresp_err_first", err_log[base], 1);
    check("hresp_err_next", err_log[base+1], 0);

    // Reset with AP and DP both occupied by client-0 reads (last is now 0).
    base = acc_owner_log.size();
    cmdq0.push_back(mk(0, 32'h0, 0));
    cmdq0.push_back(mk(0, 32'h4, 0));
    for (int n = 0; n < 50 && acc_owner_log.size() < base + 2; n++) begin
      @(posedge HCLK);
      #2;
    end
    check("pre_rst_hsel", ahb.HSEL, 1);
    n_rsp = rsp_count;
    HRESETn = 1'b0;
    cmdq0.delete(); cmdq1.delete(); expq.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("midrst_htrans", ahb.HTRANS, 2'b00);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    check("midrst_no_rsp", rsp_count - n_rsp, 0);
    base = acc_owner_log.size();
    cmdq0.push_back(mk(0, 32'h0, 0));
    cmdq1.push_back(mk(0, 32'h4, 0));
    drain("post_rst", 50);
    check("post_rst_grant", acc_owner_log[base], 0);

    // Randomized traffic with wait states and idle gaps.
    for (int i = 8; i < 16; i++) cmdq1.push_back(mk(1, 32'(i * 4), $urandom));
    drain("fill", 80);
    wait_en = 1;
    gap_pct = 30;
    for (int i = 0; i < 150; i++) begin
      cmdq0.push_back(($urandom_range(0, 19) == 0) ? mk(1, ERR_ADDR, $urandom) :
                      mk($urandom_range(0, 1) == 1, 32'($urandom_range(0, 15) * 4), $urandom));
      cmdq1.push_back(mk($urandom_range(0, 1) == 1, 32'($urandom_range(0, 15) * 4), $urandom));
    end
    drain("random", 5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
